port_alloc_sched: RTL

Sequential port allocator/scheduler for one 5-port router.
- Takes per-input output-port requests and per-output downstream readiness.
- Produces a registered, conflict-free input-to-output allocation.
- Round-robin fairness with per-output packet locks that hold an output for one packet until its tail flit.
- Sits between the input buffers / route computation and the crossbar select logic.

---
 rtl/port_alloc_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/port_alloc_sched.sv
// Two-stage separable allocator for a 5-port router: input-first round-robin
// selection, then output round-robin arbitration, with per-output packet locks.
module port_alloc_sched #(
  parameter int NUM_PORT = 5,
  parameter int PTR_W    = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_PORT*NUM_PORT-1:0]   req_vector,
  input  logic [NUM_PORT-1:0]            valid_in,
  input  logic [NUM_PORT-1:0]            tail_in,
  input  logic [NUM_PORT-1:0]            out_ready,
  output logic [NUM_PORT*NUM_PORT-1:0]   alloc_vector,
  output logic [NUM_PORT-1:0]            grant_valid,
  output logic [NUM_PORT-1:0]            out_locked
);

  logic [PTR_W-1:0]    in_ptr    [NUM_PORT];
  logic [PTR_W-1:0]    out_ptr   [NUM_PORT];
  logic [PTR_W-1:0]    owner     [NUM_PORT];
  logic                armed;

  logic [NUM_PORT-1:0] eligible;
  logic [NUM_PORT-1:0] owns_lock [NUM_PORT];
  logic [NUM_PORT-1:0] eff       [NUM_PORT];
  logic [NUM_PORT-1:0] pick      [NUM_PORT];
  logic [NUM_PORT-1:0] cand      [NUM_PORT];
  logic [NUM_PORT-1:0] win       [NUM_PORT];
  logic [NUM_PORT*NUM_PORT-1:0] alloc_next;

  function automatic logic [NUM_PORT-1:0] rr_pick(
    input logic [NUM_PORT-1:0] req,
    input logic [PTR_W-1:0]    ptr
  );
    logic [NUM_PORT-1:0] grant;
    logic                found;
    int                  idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORT; k++) begin
      idx = (int'(ptr) + k) % NUM_PORT;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input int idx);
    return PTR_W'((idx + 1) % NUM_PORT);
  endfunction

  // An input just granted is busy for one cycle; nothing is eligible until the
  // first edge after reset release has passed.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      eligible[i] = valid_in[i] & ~grant_valid[i] & armed;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORT; i++) begin
      owns_lock[i] = '0;
      for (int x = 0; x < NUM_PORT; x++) begin
        owns_lock[i][x] = out_locked[x] & (owner[x] == PTR_W'(i));
      end
    end
  end

  // A locked output only serves its owner, and a lock owner may only use its
  // locked output.
  always_comb begin
    for (int i = 0; i < NUM_PORT; i++) begin
      eff[i] = '0;
      for (int o = 0; o < NUM_PORT; o++) begin
        eff[i][o] = req_vector[i*NUM_PORT + o] & eligible[i] & out_ready[o]
                  & (~out_locked[o] | (owner[o] == PTR_W'(i)))
                  & ~(|(owns_lock[i] & ~(NUM_PORT'(1) << o)));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORT; i++) begin
      pick[i] = rr_pick(eff[i], in_ptr[i]);
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORT; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
        cand[o][i] = pick[i][o];
      end
      win[o] = rr_pick(cand[o], out_ptr[o]);
    end
  end

  always_comb begin
    alloc_next = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      for (int o = 0; o < NUM_PORT; o++) begin
        alloc_next[i*NUM_PORT + o] = win[o][i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed        <= 1'b0;
      alloc_vector <= '0;
      grant_valid  <= '0;
      out_locked   <= '0;
      for (int p = 0; p < NUM_PORT; p++) begin
        in_ptr[p]  <= '0;
        out_ptr[p] <= '0;
        owner[p]   <= '0;
      end
    end else begin
      armed        <= 1'b1;
      alloc_vector <= alloc_next;
      for (int i = 0; i < NUM_PORT; i++) begin
        grant_valid[i] <= |alloc_next[i*NUM_PORT +: NUM_PORT];
      end
      // Only granted pairs move pointers or touch locks; a tail flit releases.
      for (int o = 0; o < NUM_PORT; o++) begin
        for (int i = 0; i < NUM_PORT; i++) begin
          if (win[o][i]) begin
            out_ptr[o] <= next_ptr(i);
            in_ptr[i]  <= next_ptr(o);
            if (tail_in[i]) begin
              out_locked[o] <= 1'b0;
            end else begin
              out_locked[o] <= 1'b1;
              owner[o]      <= PTR_W'(i);
            end
          end
        end
      end
    end
  end

endmodule
